main_source: RTL and testbench



---
 rtl/main_source_if.sv | 23 ++
 rtl/main_source.sv | 43 ++++
 tb/tb_main_source.sv | 122 ++++++++++++
 3 files changed

// File: rtl/main_source_if.sv
// Operand/mode/result bundle for the main_source load/accumulate unit.
// The master drives the operand and mode flag; the slave returns the accumulator.
interface main_source_if #(
    parameter int unsigned WIDTH = 8
);

    logic [WIDTH-1:0] x_in;
    logic             flag;
    logic [WIDTH-1:0] y_out;

    modport master (
        output x_in,
        output flag,
        input  y_out
    );

    modport slave (
        input  x_in,
        input  flag,
        output y_out
    );

endinterface

// File: rtl/main_source.sv
// Registered load/accumulate unit: flag=0 loads x_in, flag=1 adds x_in to the accumulator.
// Define MAIN_SOURCE_SAT_EN for saturating accumulation; otherwise the sum wraps.
module main_source #(
    parameter int unsigned WIDTH = 8
) (
    input logic          clk,
    input logic          rst,
    main_source_if.slave bus
);

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH:0]   sum;

    // Sum kept one bit wider so the MSB is the carry out.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, bus.x_in};
    end

    always_comb begin
        acc_d = acc_q;
        if (bus.flag) begin
`ifdef MAIN_SOURCE_SAT_EN
            acc_d = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
            acc_d = sum[WIDTH-1:0];
`endif
        end else begin
            acc_d = bus.x_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign bus.y_out = acc_q;

endmodule

// File: tb/tb_main_source.sv
// Randomized bench for main_source with an arithmetic reference model and pinned lab vectors.
// Build with MAIN_SOURCE_SAT_EN defined to check the saturating variant.
module tb_main_source;

    logic clk = 1'b0;
    logic rst;

    main_source_if #(.WIDTH(8)) bus ();

    main_source #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int vectors     = 0;
    int miscompares = 0;
    int model       = 0;
    int cycle       = 0;

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the sampled inputs, checked 1 ns after each edge.
    always @(posedge clk) begin
        int s;
        cycle++;
        if (rst === 1'b1) begin
            model = 0;
        end else if (bus.flag === 1'b0) begin
            model = int'(bus.x_in);
        end else begin
            s = model + int'(bus.x_in);
`ifdef MAIN_SOURCE_SAT_EN
            if (s > 255) s = 255;
`else
            s = s % 256;
`endif
            model = s;
        end
        #1;
        vectors++;
        if (bus.y_out !== model[7:0]) begin
            miscompares++;
            $display("FAIL cycle %0d: y_out=%02h expected=%02h", cycle, bus.y_out, model[7:0]);
        end
    end

    task automatic step(input logic r, input logic f, input logic [7:0] x);
        rst      = r;
        bus.flag = f;
        bus.x_in = x;
        @(posedge clk);
        #2;
    endtask

    task automatic expect_lit(input string name, input logic [7:0] exp);
        vectors++;
        if (bus.y_out !== exp || model[7:0] !== exp) begin
            miscompares++;
            $display("FAIL %s: y_out=%02h model=%02h expected=%02h",
                     name, bus.y_out, model[7:0], exp);
        end
    endtask

    initial begin
        rst      = 1'b1;
        bus.flag = 1'b1;
        bus.x_in = 8'hAA;

        step(1'b1, 1'b1, 8'hAA);
        step(1'b1, 1'b1, 8'hAA);
        expect_lit("reset", 8'h00);

        step(1'b0, 1'b0, 8'h21); expect_lit("lab_load21", 8'h21);
        step(1'b0, 1'b1, 8'h01); expect_lit("lab_acc01", 8'h22);
        step(1'b0, 1'b0, 8'h0F); expect_lit("lab_load0f", 8'h0F);
        step(1'b0, 1'b1, 8'hF0); expect_lit("lab_accf0", 8'hFF);

        step(1'b0, 1'b0, 8'hF0); expect_lit("ovf_load", 8'hF0);
`ifdef MAIN_SOURCE_SAT_EN
        step(1'b0, 1'b1, 8'h20); expect_lit("ovf_acc20", 8'hFF);
        step(1'b0, 1'b1, 8'h01); expect_lit("ovf_acc01", 8'hFF);
`else
        step(1'b0, 1'b1, 8'h20); expect_lit("ovf_acc20", 8'h10);
        step(1'b0, 1'b1, 8'h01); expect_lit("ovf_acc01", 8'h11);
`endif

        step(1'b1, 1'b0, 8'h00); expect_lit("cont_reset", 8'h00);
        for (int i = 1; i <= 5; i++) begin
            logic [7:0] e;
            e = 8'(i);
            step(1'b0, 1'b1, 8'h01);
            expect_lit("cont_acc", e);
        end

        step(1'b1, 1'b0, 8'h00);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h10);
        step(1'b0, 1'b1, 8'h10); expect_lit("mid_acc30", 8'h30);
        step(1'b1, 1'b1, 8'h05); expect_lit("mid_reset", 8'h00);
        step(1'b0, 1'b1, 8'h05); expect_lit("mid_after", 8'h05);

        step(1'b0, 1'b0, 8'hFF); expect_lit("ld_ff", 8'hFF);
        step(1'b0, 1'b0, 8'h00); expect_lit("ld_00", 8'h00);
        step(1'b0, 1'b1, 8'h00); expect_lit("acc_00", 8'h00);

        for (int i = 0; i < 2000; i++) begin
            logic       r;
            logic       f;
            logic [7:0] x;
            r = ($urandom_range(0, 15) == 0);
            f = 1'($urandom_range(0, 1));
            x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(200, 255))
                                            : 8'($urandom_range(0, 255));
            step(r, f, x);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
